// File: rtl/adc_spi_responder_if.sv
// SPI link between the ADC-acquisition master and the emulated converter.
// The master drives clock, select and command; the responder drives data and its enable.
interface adc_spi_responder_if;
    logic sclk;
    logic csn;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output csn, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input csn, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates the board's 8-channel serial ADC as an SPI mode-0 responder.
// SPI lines are oversampled in the clk domain; channel values and fault injection come from ports.
module adc_spi_responder #(
    parameter int unsigned ADC_WIDTH  = 10,
    parameter int unsigned FRAME_BITS = ADC_WIDTH + 6
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   i_sclr,
    adc_spi_responder_if.slave     spi,
    input  logic [8*ADC_WIDTH-1:0] i_ch_data,
    input  logic                   i_force_high,
    output logic [2:0]             o_sel_ch,
    output logic                   o_sample,
    output logic                   o_frame_done,
    output logic                   o_frame_err,
    output logic [15:0]            o_frame_cnt
);
    localparam int unsigned CW = $clog2(FRAME_BITS + 1);

    // FLUSH states let the synchronizers fill after reset so a csn that is
    // already low is not mistaken for a fresh falling edge.
    typedef enum logic [2:0] {S_FLUSH0, S_FLUSH1, S_ARM, S_IDLE, S_FRAME} state_t;

    logic [1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
    logic       r_sclk_d, r_csn_d;
    logic       w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_mosi;

    state_t                 r_state, w_state;
    logic [CW-1:0]          r_cnt, w_cnt;
    logic                   r_bad, w_bad;
    logic [1:0]             r_ch_sh, w_ch_sh;
    logic [ADC_WIDTH-1:0]   r_shift, w_shift;
    logic                   r_bit, w_bit;
    logic [2:0]             r_sel_ch, w_sel_ch;
    logic                   r_oe, w_oe;
    logic                   r_miso, w_miso;
    logic                   r_sample, w_sample;
    logic                   r_done, w_done;
    logic                   r_err, w_err;
    logic [15:0]            r_frame_cnt, w_frame_cnt;
    logic [2:0]             w_ch;

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_sclk_sync <= 2'b00;
            r_csn_sync  <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
        end else if (i_sclr) begin
            r_sclk_sync <= 2'b00;
            r_csn_sync  <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi.sclk};
            r_csn_sync  <= {r_csn_sync[0], spi.csn};
            r_mosi_sync <= {r_mosi_sync[0], spi.mosi};
            r_sclk_d    <= r_sclk_sync[1];
            r_csn_d     <= r_csn_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_csn_rise  = r_csn_sync[1] & ~r_csn_d;
    assign w_csn_fall  = ~r_csn_sync[1] & r_csn_d;
    assign w_mosi      = r_mosi_sync[1];

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_bad       = r_bad;
        w_ch_sh     = r_ch_sh;
        w_shift     = r_shift;
        w_bit       = r_bit;
        w_sel_ch    = r_sel_ch;
        w_oe        = r_oe;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_frame_cnt = r_frame_cnt;
        w_ch        = {r_ch_sh, w_mosi};

        case (r_state)
            S_FLUSH0: w_state = S_FLUSH1;
            S_FLUSH1: w_state = S_ARM;
            S_ARM: begin
                if (r_csn_sync[1]) w_state = S_IDLE;
            end
            S_IDLE: begin
                if (w_csn_fall) begin
                    w_state = S_FRAME;
                    w_cnt   = '0;
                    w_bad   = 1'b0;
                    w_ch_sh = 2'b00;
                    w_bit   = 1'b0;
                    w_oe    = 1'b1;
                end
            end
            S_FRAME: begin
                // csn rise takes priority over any coincident sclk edge.
                if (w_csn_rise) begin
                    w_state = S_IDLE;
                    w_oe    = 1'b0;
                    w_bit   = 1'b0;
                    if (r_cnt == CW'(FRAME_BITS) && !r_bad) begin
                        w_done      = 1'b1;
                        w_frame_cnt = r_frame_cnt + 16'd1;
                    end else if (r_cnt != '0 || r_bad) begin
                        w_err = 1'b1;
                    end
                end else if (w_sclk_rise && r_cnt != CW'(FRAME_BITS)) begin
                    w_cnt = r_cnt + CW'(1);
                    if (r_cnt < CW'(2)) begin
                        if (!w_mosi) w_bad = 1'b1;
                    end else if (r_cnt < CW'(4)) begin
                        w_ch_sh = {r_ch_sh[0], w_mosi};
                    end else if (r_cnt == CW'(4) && !r_bad) begin
                        w_sel_ch = w_ch;
                        w_shift  = i_ch_data[32'(w_ch) * ADC_WIDTH +: ADC_WIDTH];
                        w_sample = 1'b1;
                    end
                end else if (w_sclk_fall) begin
                    // Falling edges after the null bit shift the held value out MSB first.
                    if (!r_bad && r_cnt >= CW'(6) && r_cnt < CW'(FRAME_BITS)) begin
                        w_bit   = r_shift[ADC_WIDTH-1];
                        w_shift = {r_shift[ADC_WIDTH-2:0], 1'b0};
                    end else begin
                        w_bit = 1'b0;
                    end
                end
            end
            default: w_state = S_FLUSH0;
        endcase

        w_miso = w_oe & (i_force_high | w_bit);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state     <= S_FLUSH0;
            r_cnt       <= '0;
            r_bad       <= 1'b0;
            r_ch_sh     <= 2'b00;
            r_shift     <= '0;
            r_bit       <= 1'b0;
            r_sel_ch    <= 3'd0;
            r_oe        <= 1'b0;
            r_miso      <= 1'b0;
            r_sample    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else if (i_sclr) begin
            r_state     <= S_FLUSH0;
            r_cnt       <= '0;
            r_bad       <= 1'b0;
            r_ch_sh     <= 2'b00;
            r_shift     <= '0;
            r_bit       <= 1'b0;
            r_sel_ch    <= 3'd0;
            r_oe        <= 1'b0;
            r_miso      <= 1'b0;
            r_sample    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_bad       <= w_bad;
            r_ch_sh     <= w_ch_sh;
            r_shift     <= w_shift;
            r_bit       <= w_bit;
            r_sel_ch    <= w_sel_ch;
            r_oe        <= w_oe;
            r_miso      <= w_miso;
            r_sample    <= w_sample;
            r_done      <= w_done;
            r_err       <= w_err;
            r_frame_cnt <= w_frame_cnt;
        end
    end

    assign spi.miso     = r_miso;
    assign spi.miso_oe  = r_oe;
    assign o_sel_ch     = r_sel_ch;
    assign o_sample     = r_sample;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Drives SPI frames as the ADC master and checks each against a frame-level model
// built from the command rules (start/SGL/channel, data on edges 7..16).
module tb_adc_spi_responder;
    localparam int unsigned W    = 10;
    localparam int unsigned FB   = W + 6;
    localparam int unsigned HALF = 6;

    typedef struct packed {
        logic [31:0] miso;
        logic        oe_ok;
        logic [7:0]  samples;
        logic [7:0]  dones;
        logic [7:0]  errs;
        logic [2:0]  sel;
        logic [15:0] fcnt;
    } frame_t;

    logic           clk = 1'b0;
    logic           aclr, sclr, force_high;
    logic [8*W-1:0] ch_data;
    logic [2:0]     sel_ch;
    logic           sample, frame_done, frame_err;
    logic [15:0]    frame_cnt;

    int checks = 0;
    int failures = 0;
    int n_sample = 0, n_done = 0, n_err = 0;
    logic [2:0]  m_sel;
    logic [15:0] m_cnt;

    adc_spi_responder_if spi();

    adc_spi_responder #(.ADC_WIDTH(W), .FRAME_BITS(FB)) dut (
        .clk(clk), .aclr(aclr), .i_sclr(sclr), .spi(spi),
        .i_ch_data(ch_data), .i_force_high(force_high),
        .o_sel_ch(sel_ch), .o_sample(sample), .o_frame_done(frame_done),
        .o_frame_err(frame_err), .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample === 1'b1) n_sample++;
        if (frame_done === 1'b1) n_done++;
        if (frame_err === 1'b1) n_err++;
    end

    function automatic logic [31:0] cmd_seq(input bit start, input bit sgl, input logic [2:0] ch);
        logic [31:0] s;
        s = $urandom;
        s[0] = start; s[1] = sgl; s[2] = ch[2]; s[3] = ch[1]; s[4] = ch[0];
        return s;
    endfunction

    function automatic logic [W-1:0] data_of(input logic [31:0] m);
        logic [W-1:0] d;
        for (int k = 7; k <= FB; k++) d[FB-k] = m[k-1];
        return d;
    endfunction

    // Frame-level reference: what the master should see for this command.
    task automatic model_frame(input logic [31:0] ms, input int n, input logic [8*W-1:0] chd,
                               input bit frc, output frame_t e);
        bit valid;
        int ch;
        logic [W-1:0] val;
        e = '0;
        e.oe_ok = 1'b1;
        valid = (n >= 5) && ms[0] && ms[1];
        ch = {ms[2], ms[3], ms[4]};
        val = chd[ch*W +: W];
        for (int k = 1; k <= n; k++)
            e.miso[k-1] = frc ? 1'b1 : ((valid && k >= 7 && k <= FB) ? val[FB-k] : 1'b0);
        e.samples = valid ? 8'd1 : 8'd0;
        e.dones = (valid && n >= FB) ? 8'd1 : 8'd0;
        e.errs = (e.dones == 8'd0 && n > 0) ? 8'd1 : 8'd0;
        if (valid) m_sel = 3'(ch);
        m_cnt = m_cnt + 16'(e.dones);
        e.sel = m_sel;
        e.fcnt = m_cnt;
    endtask

    task automatic xfer(input logic [31:0] ms, input int n, input bit chg,
                        input logic [8*W-1:0] chg_val, output frame_t o);
        int s0, d0, e0;
        s0 = n_sample; d0 = n_done; e0 = n_err;
        o = '0;
        o.oe_ok = 1'b1;
        @(negedge clk);
        spi.csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi.mosi = ms[i];
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b1;
            o.miso[i] = spi.miso;
            if (spi.miso_oe !== 1'b1) o.oe_ok = 1'b0;
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b0;
            if (chg && i == 4) ch_data = chg_val;
        end
        repeat (HALF) @(negedge clk);
        spi.csn = 1'b1;
        repeat (8) @(negedge clk);
        o.samples = 8'(n_sample - s0);
        o.dones = 8'(n_done - d0);
        o.errs = 8'(n_err - e0);
        o.sel = sel_ch;
        o.fcnt = frame_cnt;
    endtask

    task automatic test_reset();
        aclr = 1'b1; sclr = 1'b0; force_high = 1'b0; ch_data = '0;
        spi.sclk = 1'b0; spi.csn = 1'b1; spi.mosi = 1'b0;
        m_sel = 3'd0; m_cnt = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi.miso, spi.miso_oe, sel_ch, sample, frame_done, frame_err, frame_cnt} !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs got miso=%b oe=%b sel=%0d smp=%b done=%b err=%b cnt=%0d exp all 0",
                     spi.miso, spi.miso_oe, sel_ch, sample, frame_done, frame_err, frame_cnt);
        end
        aclr = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single_read();
        frame_t o, e;
        logic [31:0] ms;
        ch_data = '0;
        ch_data[3*W +: W] = 10'h2A5;
        ms = cmd_seq(1'b1, 1'b1, 3'd3);
        model_frame(ms, FB, ch_data, 1'b0, e);
        xfer(ms, FB, 1'b0, '0, o);
        checks++;
        if (o !== e) begin failures++; $display("FAIL single_frame got=%p exp=%p", o, e); end
        checks++;
        if (data_of(o.miso) !== 10'h2A5 || sel_ch !== 3'd3 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL single_value got data=%h sel=%0d cnt=%0d exp 2a5/3/1", data_of(o.miso), sel_ch, frame_cnt);
        end
        checks++;
        if (spi.miso_oe !== 1'b0 || spi.miso !== 1'b0) begin
            failures++; $display("FAIL single_idle got oe=%b miso=%b exp 0/0", spi.miso_oe, spi.miso);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [8];
        frame_t o, e;
        logic [31:0] ms;
        int e0;
        vals = '{10'h111, 10'h222, 10'h333, 10'h044, 10'h155, 10'h266, 10'h377, 10'h088};
        for (int c = 0; c < 8; c++) ch_data[c*W +: W] = vals[c];
        e0 = n_err;
        for (int c = 0; c < 8; c++) begin
            ms = cmd_seq(1'b1, 1'b1, 3'(c));
            model_frame(ms, FB, ch_data, 1'b0, e);
            xfer(ms, FB, 1'b0, '0, o);
            checks++;
            if (o !== e || data_of(o.miso) !== vals[c]) begin
                failures++; $display("FAIL b2b_ch%0d got=%p exp=%p", c, o, e);
            end
        end
        checks++;
        if (frame_cnt !== 16'd9 || n_err != e0) begin
            failures++; $display("FAIL b2b_totals got cnt=%0d errs=%0d exp 9/0", frame_cnt, n_err - e0);
        end
    endtask

    task automatic test_bad_start();
        frame_t o, e;
        logic [31:0] ms;
        ms = cmd_seq(1'b0, 1'b1, 3'd2);
        model_frame(ms, FB, ch_data, 1'b0, e);
        xfer(ms, FB, 1'b0, '0, o);
        checks++;
        if (o !== e || o.miso !== 32'd0 || o.samples !== 8'd0 || o.errs !== 8'd1 || o.fcnt !== 16'd9) begin
            failures++; $display("FAIL bad_start got=%p exp=%p", o, e);
        end
    endtask

    task automatic test_abort();
        frame_t o, e;
        logic [31:0] ms;
        ch_data[5*W +: W] = 10'h2DB;
        ms = cmd_seq(1'b1, 1'b1, 3'd5);
        model_frame(ms, 8, ch_data, 1'b0, e);
        xfer(ms, 8, 1'b0, '0, o);
        checks++;
        if (o !== e || o.samples !== 8'd1 || o.errs !== 8'd1 || o.dones !== 8'd0) begin
            failures++; $display("FAIL abort got=%p exp=%p", o, e);
        end
        ms = cmd_seq(1'b1, 1'b1, 3'd5);
        model_frame(ms, FB, ch_data, 1'b0, e);
        xfer(ms, FB, 1'b0, '0, o);
        checks++;
        if (o !== e || data_of(o.miso) !== 10'h2DB) begin
            failures++; $display("FAIL abort_next got=%p exp=%p", o, e);
        end
    endtask

    task automatic test_hold_and_force();
        frame_t o, e;
        logic [31:0] ms;
        logic [8*W-1:0] changed;
        ch_data[2*W +: W] = 10'h3FF;
        changed = ch_data;
        changed[2*W +: W] = 10'h000;
        ms = cmd_seq(1'b1, 1'b1, 3'd2);
        model_frame(ms, FB, ch_data, 1'b0, e);
        xfer(ms, FB, 1'b1, changed, o);
        checks++;
        if (o !== e || data_of(o.miso) !== 10'h3FF) begin
            failures++; $display("FAIL hold_value got=%p exp=%p", o, e);
        end
        force_high = 1'b1;
        ms = cmd_seq(1'b1, 1'b1, 3'd2);
        model_frame(ms, FB, ch_data, 1'b1, e);
        xfer(ms, FB, 1'b0, '0, o);
        force_high = 1'b0;
        checks++;
        if (o !== e || o.miso[FB-1:0] !== 16'hFFFF || o.dones !== 8'd1) begin
            failures++; $display("FAIL force_high got=%p exp=%p", o, e);
        end
    endtask

    task automatic test_reset_midframe();
        frame_t o, e;
        logic [31:0] ms;
        int s0, d0, e0;
        ch_data[1*W +: W] = 10'h155;
        ms = cmd_seq(1'b1, 1'b1, 3'd1);
        @(negedge clk);
        spi.csn = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            spi.mosi = ms[i];
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b1;
            if (i < 8) begin repeat (HALF) @(negedge clk); spi.sclk = 1'b0; end
        end
        repeat (3) @(negedge clk);
        s0 = n_sample; d0 = n_done; e0 = n_err;
        aclr = 1'b1;
        @(negedge clk);
        m_sel = 3'd0; m_cnt = 16'd0;
        checks++;
        if ({spi.miso, spi.miso_oe, sel_ch, frame_cnt} !== 21'd0) begin
            failures++;
            $display("FAIL midframe_reset got miso=%b oe=%b sel=%0d cnt=%0d exp all 0",
                     spi.miso, spi.miso_oe, sel_ch, frame_cnt);
        end
        repeat (2) @(negedge clk);
        aclr = 1'b0;
        spi.sclk = 1'b0;
        for (int i = 0; i < 7; i++) begin
            repeat (HALF) @(negedge clk); spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk); spi.sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi.csn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (n_sample != s0 || n_done != d0 || n_err != e0 || spi.miso_oe !== 1'b0) begin
            failures++;
            $display("FAIL midframe_pulses got smp=%0d done=%0d err=%0d oe=%b exp 0/0/0/0",
                     n_sample - s0, n_done - d0, n_err - e0, spi.miso_oe);
        end
        ms = cmd_seq(1'b1, 1'b1, 3'd1);
        model_frame(ms, FB, ch_data, 1'b0, e);
        xfer(ms, FB, 1'b0, '0, o);
        checks++;
        if (o !== e || data_of(o.miso) !== 10'h155 || o.fcnt !== 16'd1) begin
            failures++; $display("FAIL midframe_next got=%p exp=%p", o, e);
        end
    endtask

    task automatic test_sclr();
        @(negedge clk);
        sclr = 1'b1;
        repeat (2) @(negedge clk);
        m_sel = 3'd0; m_cnt = 16'd0;
        checks++;
        if (frame_cnt !== 16'd0 || sel_ch !== 3'd0 || spi.miso_oe !== 1'b0) begin
            failures++; $display("FAIL sclr got cnt=%0d sel=%0d oe=%b exp 0/0/0", frame_cnt, sel_ch, spi.miso_oe);
        end
        sclr = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        frame_t o, e;
        logic [31:0] ms;
        int n;
        bit frc;
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 8; c++) ch_data[c*W +: W] = W'($urandom);
            frc = ($urandom_range(0, 3) == 0);
            ms = cmd_seq($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom));
            n = ($urandom_range(0, 9) < 6) ? int'(FB) : int'($urandom_range(0, 20));
            force_high = frc;
            model_frame(ms, n, ch_data, frc, e);
            xfer(ms, n, 1'b0, '0, o);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random_%0d n=%0d got=%p exp=%p", t, n, o, e); end
        end
        force_high = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_bad_start();
        test_abort();
        test_hold_and_force();
        test_reset_midframe();
        test_sclr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
